// File: rtl/store_write_buffer.sv
// Store write buffer: aligns MEM-stage stores into byte lanes and queues
// them in a small FIFO that drains into the data RAM on ack.
module store_write_buffer #(
    parameter int DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        store_valid,
    output logic        store_ready,
    input  logic [31:0] store_addr,
    input  logic [31:0] store_data,
    input  logic [3:0]  mem_sel,
    output logic        ram_write_en,
    output logic [31:0] ram_addr,
    output logic [3:0]  ram_write_sel,
    output logic [31:0] ram_write_data,
    input  logic        ram_write_ack,
    output logic        misalign_err,
    input  logic [31:0] load_check_addr,
    output logic        load_conflict,
    output logic        empty
);

    localparam int AW = $clog2(DEPTH);

    logic [31:0]   r_addr [DEPTH];
    logic [3:0]    r_sel  [DEPTH];
    logic [31:0]   r_data [DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [AW:0]   r_count;
    logic          r_mis;

    logic          w_ok;
    logic [3:0]    w_sel;
    logic [31:0]   w_data;
    logic [31:0]   w_waddr;
    logic [31:0]   w_lca;
    logic          w_empty;
    logic          w_full;
    logic          w_acc;
    logic          w_push;
    logic          w_pop;
    logic          w_lc;
    logic [AW-1:0] w_off;

    always_comb begin
        w_ok   = 1'b0;
        w_sel  = 4'b0000;
        w_data = 32'h0;
        case (mem_sel)
            4'b0001: begin
                w_ok   = 1'b1;
                w_sel  = 4'b0001 << store_addr[1:0];
                w_data = {4{store_data[7:0]}};
            end
            4'b0011: begin
                w_ok   = !store_addr[0];
                w_sel  = store_addr[1] ? 4'b1100 : 4'b0011;
                w_data = {2{store_data[15:0]}};
            end
            4'b1111: begin
                w_ok   = (store_addr[1:0] == 2'b00);
                w_sel  = 4'b1111;
                w_data = store_data;
            end
            default: ;
        endcase
    end

    assign w_waddr = {store_addr[31:2], 2'b00};
    assign w_lca   = load_check_addr & 32'hFFFF_FFFC;
    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == (AW+1)'(DEPTH));
    assign w_acc   = store_valid && !w_full;
    assign w_push  = w_acc && w_ok;
    assign w_pop   = !w_empty && ram_write_ack;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_mis   <= 1'b0;
        end else begin
            r_mis <= w_acc && !w_ok;
            if (w_push) r_wptr <= r_wptr + AW'(1);
            if (w_pop)  r_rptr <= r_rptr + AW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: ;
            endcase
        end
    end

    // Entry payload is not reset; validity comes only from pointers/count.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_addr[r_wptr] <= w_waddr;
            r_sel[r_wptr]  <= w_sel;
            r_data[r_wptr] <= w_data;
        end
    end

    always_comb begin
        w_lc  = 1'b0;
        w_off = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_off = AW'(i) - r_rptr;
            if (({1'b0, w_off} < r_count) && (r_addr[i] == w_lca))
                w_lc = 1'b1;
        end
    end

    assign store_ready    = !w_full;
    assign empty          = w_empty;
    assign ram_write_en   = !w_empty;
    assign ram_addr       = w_empty ? 32'h0 : r_addr[r_rptr];
    assign ram_write_sel  = w_empty ? 4'h0  : r_sel[r_rptr];
    assign ram_write_data = w_empty ? 32'h0 : r_data[r_rptr];
    assign misalign_err   = r_mis;
    assign load_conflict  = w_lc;

endmodule

// File: tb/tb_store_write_buffer.sv
// Bench for store_write_buffer: directed scenarios plus random traffic
// compared against a queue-based reference model.
module tb_store_write_buffer;

    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        store_valid = 1'b0;
    logic        store_ready;
    logic [31:0] store_addr = '0;
    logic [31:0] store_data = '0;
    logic [3:0]  mem_sel = '0;
    logic        ram_write_en;
    logic [31:0] ram_addr;
    logic [3:0]  ram_write_sel;
    logic [31:0] ram_write_data;
    logic        ram_write_ack = 1'b0;
    logic        misalign_err;
    logic [31:0] load_check_addr = '0;
    logic        load_conflict;
    logic        empty;

    store_write_buffer #(.DEPTH(DEPTH)) dut (
        .clk(clk),
        .rst(rst),
        .store_valid(store_valid),
        .store_ready(store_ready),
        .store_addr(store_addr),
        .store_data(store_data),
        .mem_sel(mem_sel),
        .ram_write_en(ram_write_en),
        .ram_addr(ram_addr),
        .ram_write_sel(ram_write_sel),
        .ram_write_data(ram_write_data),
        .ram_write_ack(ram_write_ack),
        .misalign_err(misalign_err),
        .load_check_addr(load_check_addr),
        .load_conflict(load_conflict),
        .empty(empty)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  sel;
        logic [31:0] data;
    } ent_t;

    ent_t q[$];
    bit   exp_mis = 0;
    int   checks = 0;
    int   failures = 0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic bit model_align(input logic [31:0] a,
                                       input logic [31:0] d,
                                       input logic [3:0] s,
                                       output ent_t e);
        int lane;
        lane = int'(a % 4);
        e.addr = a - 32'(lane);
        e.sel  = 4'h0;
        e.data = 32'h0;
        if (s == 4'b0001) begin
            e.sel  = 4'(1 << lane);
            e.data = 32'(d[7:0]) * 32'h0101_0101;
            return 1;
        end
        if (s == 4'b0011 && lane % 2 == 0) begin
            e.sel  = 4'(3 << lane);
            e.data = 32'(d[15:0]) * 32'h0001_0001;
            return 1;
        end
        if (s == 4'b1111 && lane == 0) begin
            e.sel  = 4'hF;
            e.data = d;
            return 1;
        end
        return 0;
    endfunction

    task automatic check_outputs();
        bit lc;
        lc = 0;
        foreach (q[i])
            if (q[i].addr[31:2] == load_check_addr[31:2]) lc = 1;
        check("ready", 32'(store_ready), 32'(q.size() < DEPTH));
        check("empty", 32'(empty), 32'(q.size() == 0));
        check("wen", 32'(ram_write_en), 32'(q.size() != 0));
        check("addr", ram_addr, q.size() ? q[0].addr : 32'h0);
        check("sel", 32'(ram_write_sel), q.size() ? 32'(q[0].sel) : 32'h0);
        check("data", ram_write_data, q.size() ? q[0].data : 32'h0);
        check("mis", 32'(misalign_err), 32'(exp_mis));
        check("lconf", 32'(load_conflict), 32'(lc));
    endtask

    // Called just after a rising edge; returns just after the next one.
    task automatic cycle(input bit v, input logic [31:0] a,
                         input logic [31:0] d, input logic [3:0] s,
                         input bit ack, input logic [31:0] lca);
        ent_t e;
        bit   ok;
        bit   acc;
        store_valid = v;
        store_addr = a;
        store_data = d;
        mem_sel = s;
        ram_write_ack = ack;
        load_check_addr = lca;
        @(negedge clk);
        check_outputs();
        @(posedge clk);
        ok  = model_align(a, d, s, e);
        acc = v && (q.size() < DEPTH);
        if (ack && q.size() > 0) void'(q.pop_front());
        exp_mis = acc && !ok;
        if (acc && ok) q.push_back(e);
        #1;
    endtask

    task automatic idle(input bit ack);
        cycle(0, 32'h0, 32'h0, 4'h0, ack, 32'hFFFF_FFF0);
    endtask

    task automatic check_reset_vals();
        check("rst_wen", 32'(ram_write_en), 32'h0);
        check("rst_addr", ram_addr, 32'h0);
        check("rst_sel", 32'(ram_write_sel), 32'h0);
        check("rst_data", ram_write_data, 32'h0);
        check("rst_mis", 32'(misalign_err), 32'h0);
        check("rst_lconf", 32'(load_conflict), 32'h0);
        check("rst_empty", 32'(empty), 32'h1);
        check("rst_ready", 32'(store_ready), 32'h1);
    endtask

    initial begin
        logic [3:0] s;
        #1;
        check_reset_vals();
        @(posedge clk);
        #1;
        rst = 1'b1;

        // Byte store lane alignment
        cycle(1, 32'h1003, 32'h0000_00A5, 4'b0001, 0, 32'h0);
        check("byte_addr", ram_addr, 32'h1000);
        check("byte_sel", 32'(ram_write_sel), 32'h8);
        check("byte_data", ram_write_data, 32'hA5A5_A5A5);
        idle(1);

        // Half store, aligned then misaligned
        cycle(1, 32'h2002, 32'h0000_BEEF, 4'b0011, 0, 32'h0);
        check("half_sel", 32'(ram_write_sel), 32'hC);
        check("half_data", ram_write_data, 32'hBEEF_BEEF);
        idle(1);
        cycle(1, 32'h2001, 32'h0000_BEEF, 4'b0011, 0, 32'h0);
        check("mis_pulse", 32'(misalign_err), 32'h1);
        check("mis_empty", 32'(empty), 32'h1);
        idle(0);
        check("mis_one", 32'(misalign_err), 32'h0);

        // Back-pressure: fill, try a third store, then drain in order
        cycle(1, 32'h0, 32'h1111_1111, 4'hF, 0, 32'h0);
        cycle(1, 32'h4, 32'h2222_2222, 4'hF, 0, 32'h0);
        cycle(1, 32'h8, 32'h3333_3333, 4'hF, 0, 32'h0);
        check("bp_ready", 32'(store_ready), 32'h0);
        check("bp_head", ram_addr, 32'h0);
        cycle(1, 32'hC, 32'h4444_4444, 4'hF, 1, 32'h0);
        check("bp_pop1", ram_addr, 32'h4);
        check("bp_ready1", 32'(store_ready), 32'h1);
        idle(1);
        check("bp_drained", 32'(empty), 32'h1);

        // Simultaneous push and pop
        cycle(1, 32'h100, 32'hAAAA_0001, 4'hF, 0, 32'h0);
        cycle(1, 32'h200, 32'hBBBB_0002, 4'hF, 1, 32'h0);
        check("pp_count", 32'(q.size()), 32'h1);
        check("pp_head", ram_addr, 32'h200);
        idle(1);

        // Load conflict
        cycle(1, 32'h3000, 32'h5, 4'hF, 0, 32'h0);
        load_check_addr = 32'h3002;
        #1;
        check("lc_hit", 32'(load_conflict), 32'h1);
        load_check_addr = 32'h3004;
        #1;
        check("lc_miss", 32'(load_conflict), 32'h0);
        idle(1);

        // Asynchronous reset with two entries pending
        cycle(1, 32'h40, 32'h1, 4'hF, 0, 32'h0);
        cycle(1, 32'h44, 32'h2, 4'hF, 0, 32'h0);
        check("pre_rst_full", 32'(store_ready), 32'h0);
        store_valid = 0;
        ram_write_ack = 1;
        #2;
        rst = 1'b0;
        #1;
        check_reset_vals();
        q.delete();
        exp_mis = 0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        cycle(1, 32'h50, 32'h0000_0077, 4'b0001, 1, 32'h0);
        check("post_rst_acc", 32'(empty), 32'h0);
        idle(1);

        // Random traffic
        for (int n = 0; n < 400; n++) begin
            case ($urandom_range(0, 4))
                0:       s = 4'b0001;
                1:       s = 4'b0011;
                2, 3:    s = 4'b1111;
                default: s = 4'($urandom);
            endcase
            cycle(1'($urandom_range(0, 1)), 32'($urandom_range(0, 63)),
                  $urandom, s, 1'($urandom_range(0, 2) == 0),
                  32'($urandom_range(0, 63)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/store_write_buffer.md
STORE_WRITE_BUFFER -- requirements
Module: store_write_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 2: number of buffered store entries; power of two, at least 2.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on the rising edge.
REQ-003 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port store_valid  input  1  MEM stage presents a store this cycle.
REQ-005 SHALL have port store_ready  output  1  buffer can accept a store this cycle.
REQ-006 SHALL have port store_addr  input  32  byte address of the store.
REQ-007 SHALL have port store_data  input  32  unaligned store data; byte/half in the low bits.
REQ-008 SHALL have port mem_sel  input  4  access size: 4'b0001 byte, 4'b0011 half, 4'b1111 word.
REQ-009 SHALL have port ram_write_en  output  1  RAM write request valid.
REQ-010 SHALL have port ram_addr  output  32  word-aligned RAM address, with bits [1:0] = 0.
REQ-011 SHALL have port ram_write_sel  output  4  byte-lane write enables; bit n enables data[8n+7:8n].
REQ-012 SHALL have port ram_write_data  output  32  lane-aligned write data.
REQ-013 SHALL have port ram_write_ack  input  1  RAM accepted the current request this cycle.
REQ-014 SHALL have port misalign_err  output  1  one-cycle pulse when a store is dropped.
REQ-015 SHALL have port load_check_addr  input  32  load address from the MEM stage.
REQ-016 SHALL have port load_conflict  output  1  a pending store targets the same word as load_check_addr.
REQ-017 SHALL have port empty  output  1  no pending entries.

Function
REQ-018 SHALL set store_ready = !full; a store is accepted when store_valid && store_ready at a rising edge.
REQ-019 SHALL align a byte store as follows: ram_write_sel = 4'b0001 << addr[1:0], and data = store_data[7:0] replicated in all four lanes.
REQ-020 SHALL align a half store with addr[1:0]=00 as sel 4'b0011 and with addr[1:0]=10 as sel 4'b1100; in both cases data = {2{store_data[15:0]}}.
REQ-021 SHALL align a word store with addr[1:0]=00 as sel 4'b1111 and data = store_data.
REQ-022 SHALL treat as misaligned any half store with addr[0]=1, any word store with addr[1:0]!=00, and any other mem_sel value.
REQ-023 SHALL drop a misaligned accepted store without enqueuing it and pulse misalign_err high for exactly the following cycle.
REQ-024 SHALL store the aligned sel, data and {addr[31:2],2'b00} in the FIFO entry at the write pointer.
REQ-025 SHALL drive ram_write_en = !empty, with ram_addr, ram_write_sel and ram_write_data taken from the head entry.
REQ-026 SHALL hold the head outputs stable while ram_write_en=1 and ram_write_ack=0.
REQ-027 SHALL pop the head on a rising edge where ram_write_en && ram_write_ack; ram_write_ack while empty is ignored.
REQ-028 SHALL have a latency of one cycle: a store accepted into an empty buffer at edge N drives ram_write_en=1 after edge N; there is no combinational bypass.
REQ-029 SHALL leave count unchanged, advance both pointers, and keep FIFO order when a push and a pop occur at the same edge.
REQ-030 SHALL not accept a store while full, even if ram_write_ack=1 in the same cycle.
REQ-031 SHALL wrap read and write pointers modulo DEPTH; count ranges 0..DEPTH.
REQ-032 SHALL drive load_conflict combinationally: 1 iff some valid entry has ram_addr[31:2] == load_check_addr[31:2].
REQ-033 SHALL mask ram_write_sel, ram_addr and ram_write_data to 0 when empty.

Reset
REQ-034 SHALL, while rst=0, asynchronously clear pointers and count and drive ram_write_en=0, ram_addr=0, ram_write_sel=0, ram_write_data=0, misalign_err=0, load_conflict=0, empty=1 and store_ready=1.
REQ-035 SHALL, on reset asserted mid-transaction, discard all pending entries with no RAM write completed afterwards; entry storage contents need not be cleared.
REQ-036 SHALL accept stores on the first rising edge after rst returns high.

Verification
REQ-037 SHALL cover a byte store: addr 0x1003, data 0x000000A5, sel 0001 -> ram_addr 0x1000, ram_write_sel 1000, ram_write_data 0xA5A5A5A5 one cycle later.
REQ-038 SHALL cover a half store: addr 0x2002, data 0x0000BEEF, sel 0011 -> ram_write_sel 1100, ram_write_data 0xBEEFBEEF; with addr 0x2001 the store is dropped, misalign_err pulses for 1 cycle and empty stays 1.
REQ-039 SHALL cover back-pressure with DEPTH=2: push word stores 0x11111111@0x0 and 0x22222222@0x4 with ack held 0 -> store_ready=0 and a third store is not accepted; then ack=1 for 2 cycles -> writes appear in order 0x0 then 0x4, and store_ready returns to 1 after the first pop.
REQ-040 SHALL cover simultaneous push and pop: with one entry pending and ack=1 while a new store is accepted -> count stays 1 and the new entry is at the head next cycle.
REQ-041 SHALL cover load conflict: pending store @0x3000, load_check_addr 0x3002 -> load_conflict=1; load_check_addr 0x3004 -> load_conflict=0.
REQ-042 SHALL cover reset: assert rst=0 with 2 entries pending -> outputs go to the REQ-034 values immediately, without waiting for a clock edge.
